decode_session_controller: RTL and testbench

Synthesizable host-side sequencer that drives the Helios single-FPGA decoder's 8-bit input stream and collects its 8-bit result stream. It runs a multi-shot decoding session:
- sends START_DECODING_MSG once per session;
- for each shot, sends MEASUREMENT_DATA_HEADER, then the measurement bytes taken from an upstream byte source, then waits for and captures the result message (iteration count, 16-bit cycle count).

It sits between the syndrome byte buffer / host link and the decoder's input and output FIFOs.

---
 rtl/decode_session_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_decode_session_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_session_controller.sv
// Host-side session sequencer for the Helios decoder: START once, then HEADER + measurement bytes per shot, collecting each result.
// Optional build macro DECODE_TIMEOUT_EN adds a WAIT_RES watchdog and a sticky timeout output.
module decode_session_controller #(
  parameter int         BYTES_PER_ROUND    = 1,
  parameter int         MEASUREMENT_ROUNDS = 2,
  parameter logic [7:0] START_MSG          = 8'h01,
  parameter logic [7:0] HEADER_MSG         = 8'h02,
  parameter int         RESULT_BYTES       = 3
`ifdef DECODE_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYCLES     = 4096
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] num_shots,
  output logic        busy,
  input  logic [7:0]  meas_data,
  input  logic        meas_valid,
  output logic        meas_ready,
  output logic [7:0]  dec_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  input  logic [7:0]  res_data,
  input  logic        res_valid,
  output logic        res_ready,
  output logic        result_valid,
  output logic [7:0]  iterations,
  output logic [15:0] cycles,
  output logic [15:0] shot_index,
`ifdef DECODE_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic        session_done
);

  // state      | meaning
  // IDLE       | waiting for start
  // SEND_START | presenting START_MSG to the decoder
  // SEND_HDR   | presenting HEADER_MSG for the next shot
  // SEND_MEAS  | measurement bytes pass straight through to the decoder
  // WAIT_RES   | waiting for result byte0 (iterations)
  // RECV_RES   | collecting the remaining result bytes
  // DONE       | session finished, session_done follows
  typedef enum logic [2:0] {
    S_IDLE, S_SEND_START, S_SEND_HDR, S_SEND_MEAS, S_WAIT_RES, S_RECV_RES, S_DONE
  } state_e;

  localparam int          MEAS_PER_SHOT = BYTES_PER_ROUND * MEASUREMENT_ROUNDS;
  localparam logic [15:0] MEAS_LAST     = 16'(MEAS_PER_SHOT - 1);
  localparam logic [7:0]  RES_LAST      = 8'(RESULT_BYTES - 1);

  state_e      state_q, state_d;
  logic [15:0] shots_total_q, shots_total_d;
  logic [15:0] shot_index_q, shot_index_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  res_cnt_q, res_cnt_d;
  logic [7:0]  iter_stage_q, iter_stage_d;
  logic [7:0]  cyc_hi_q, cyc_hi_d;
  logic [7:0]  cyc_lo_q, cyc_lo_d;
  logic [7:0]  iterations_q, iterations_d;
  logic [15:0] cycles_q, cycles_d;
  logic        result_valid_q, result_valid_d;
  logic        session_done_q, session_done_d;
  logic        busy_q, busy_d;
  logic        shot_fin;
  logic        last_shot;
`ifdef DECODE_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  assign last_shot = (({1'b0, shot_index_q} + 17'd1) == {1'b0, shots_total_q});

  always_comb begin
    state_d        = state_q;
    shots_total_d  = shots_total_q;
    shot_index_d   = shot_index_q;
    byte_cnt_d     = byte_cnt_q;
    res_cnt_d      = res_cnt_q;
    iter_stage_d   = iter_stage_q;
    cyc_hi_d       = cyc_hi_q;
    cyc_lo_d       = cyc_lo_q;
    iterations_d   = iterations_q;
    cycles_d       = cycles_q;
    result_valid_d = 1'b0;
    session_done_d = (state_q == S_DONE);
    shot_fin       = 1'b0;
`ifdef DECODE_TIMEOUT_EN
    wait_cnt_d     = wait_cnt_q;
    timeout_d      = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shots_total_d = (num_shots == 16'd0) ? 16'd1 : num_shots;
          shot_index_d  = 16'd0;
          state_d       = S_SEND_START;
`ifdef DECODE_TIMEOUT_EN
          timeout_d     = 1'b0;
`endif
        end
      end
      S_SEND_START: begin
        if (dec_ready) state_d = S_SEND_HDR;
      end
      S_SEND_HDR: begin
        if (dec_ready) begin
          byte_cnt_d = 16'd0;
          state_d    = S_SEND_MEAS;
        end
      end
      S_SEND_MEAS: begin
        if (meas_valid && dec_ready) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q == MEAS_LAST) begin
            state_d = S_WAIT_RES;
`ifdef DECODE_TIMEOUT_EN
            wait_cnt_d = 32'd0;
`endif
          end
        end
      end
      S_WAIT_RES: begin
        if (res_valid) begin
          iter_stage_d = res_data;
          res_cnt_d    = 8'd1;
          if (RESULT_BYTES == 1) shot_fin = 1'b1;
          else                   state_d  = S_RECV_RES;
        end
`ifdef DECODE_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
`endif
      end
      S_RECV_RES: begin
        if (res_valid) begin
          if (res_cnt_q == 8'd1) cyc_hi_d = res_data;
          if (res_cnt_q == 8'd2) cyc_lo_d = res_data;
          res_cnt_d = res_cnt_q + 8'd1;
          if (res_cnt_q == RES_LAST) shot_fin = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Results are staged and committed together so outputs only change with result_valid.
    if (shot_fin) begin
      result_valid_d = 1'b1;
      iterations_d   = iter_stage_d;
      cycles_d       = {cyc_hi_d, cyc_lo_d};
      shot_index_d   = shot_index_q + 16'd1;
      state_d        = last_shot ? S_DONE : S_SEND_HDR;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      shots_total_q  <= '0;
      shot_index_q   <= '0;
      byte_cnt_q     <= '0;
      res_cnt_q      <= '0;
      iter_stage_q   <= '0;
      cyc_hi_q       <= '0;
      cyc_lo_q       <= '0;
      iterations_q   <= '0;
      cycles_q       <= '0;
      result_valid_q <= 1'b0;
      session_done_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef DECODE_TIMEOUT_EN
      wait_cnt_q     <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      shots_total_q  <= shots_total_d;
      shot_index_q   <= shot_index_d;
      byte_cnt_q     <= byte_cnt_d;
      res_cnt_q      <= res_cnt_d;
      iter_stage_q   <= iter_stage_d;
      cyc_hi_q       <= cyc_hi_d;
      cyc_lo_q       <= cyc_lo_d;
      iterations_q   <= iterations_d;
      cycles_q       <= cycles_d;
      result_valid_q <= result_valid_d;
      session_done_q <= session_done_d;
      busy_q         <= busy_d;
`ifdef DECODE_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  // Stream handshakes decode straight from the state flop so reset drops them at once.
  always_comb begin
    dec_valid  = 1'b0;
    dec_data   = 8'h00;
    meas_ready = 1'b0;
    res_ready  = 1'b0;
    case (state_q)
      S_SEND_START: begin
        dec_valid = 1'b1;
        dec_data  = START_MSG;
      end
      S_SEND_HDR: begin
        dec_valid = 1'b1;
        dec_data  = HEADER_MSG;
      end
      S_SEND_MEAS: begin
        dec_valid  = meas_valid;
        dec_data   = meas_data;
        meas_ready = dec_ready;
      end
      S_WAIT_RES, S_RECV_RES: res_ready = 1'b1;
      default: ;
    endcase
  end

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign iterations   = iterations_q;
  assign cycles       = cycles_q;
  assign shot_index   = shot_index_q;
  assign session_done = session_done_q;
`ifdef DECODE_TIMEOUT_EN
  assign timeout      = timeout_q;
`endif

endmodule

// File: tb/tb_decode_session_controller.sv
// Bench for decode_session_controller: table of session scenarios with random data and handshakes,
// checked against a queue-based model of the expected decoder stream and result outputs.
module tb_decode_session_controller;
  localparam int MEAS = 2;
  localparam int RB   = 3;
  localparam logic [7:0] START_B = 8'h01;
  localparam logic [7:0] HDR_B   = 8'h02;

  typedef logic [7:0] u8;
  typedef struct {
    int num_shots;
    int exp_shots;
    int mode;       // 0: dec_ready=1, 1: 1010 toggle, 2: random
    bit mgap;
    bit rgap;
    bit fixed_res;
    bit restart;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_shots = 16'd0;
  logic        busy;
  logic [7:0]  meas_data = 8'h00;
  logic        meas_valid = 1'b0;
  logic        meas_ready;
  logic [7:0]  dec_data;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [7:0]  res_data = 8'h00;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        result_valid;
  logic [7:0]  iterations;
  logic [15:0] cycles;
  logic [15:0] shot_index;
  logic        session_done;
`ifdef DECODE_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int passes = 0;
  u8  src_q[$];
  u8  res_q[$];
  u8  res_model[$];
  u8  exp_dec[$];
  bit exp_ctrl[$];
  u8  fixed_r[3] = '{8'h05, 8'h00, 8'h2A};
  vec_t vecs[7];

  always #5 clk = ~clk;

`ifdef DECODE_TIMEOUT_EN
  decode_session_controller #(.TIMEOUT_CYCLES(16)) dut (
`else
  decode_session_controller dut (
`endif
    .clk(clk), .reset_n(reset_n), .start(start), .num_shots(num_shots), .busy(busy),
    .meas_data(meas_data), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .dec_data(dec_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .result_valid(result_valid), .iterations(iterations), .cycles(cycles),
    .shot_index(shot_index),
`ifdef DECODE_TIMEOUT_EN
    .timeout(timeout),
`endif
    .session_done(session_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; start = 1'b0; meas_valid = 1'b0; dec_ready = 1'b0; res_valid = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_data", dec_data, 0);
    chk("rst_meas_ready", meas_ready, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_session_done", session_done, 0);
    chk("rst_shot_index", shot_index, 0);
    chk("rst_iterations", iterations, 0);
    chk("rst_cycles", cycles, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_session(input vec_t v, input bit expect_timeout);
    int sent_shots = expect_timeout ? 1 : v.exp_shots;
    bit m_pend = 0, r_pend = 0, prev_stall = 0, seen_done = 0;
    u8  prev_data = 8'h00;
    int cyc = 0, res_count = 0, last_rv = -100, meas_fired = 0, res_fired = 0, wait_cycles = -1;
    src_q.delete(); res_q.delete(); res_model.delete(); exp_dec.delete(); exp_ctrl.delete();
    exp_dec.push_back(START_B); exp_ctrl.push_back(1'b1);
    for (int s = 0; s < sent_shots; s++) begin
      exp_dec.push_back(HDR_B); exp_ctrl.push_back(1'b1);
      for (int b = 0; b < MEAS; b++) begin
        u8 m = 8'($urandom);
        src_q.push_back(m); exp_dec.push_back(m); exp_ctrl.push_back(1'b0);
      end
    end
    if (!expect_timeout) begin
      for (int s = 0; s < v.exp_shots; s++) begin
        for (int b = 0; b < RB; b++) begin
          u8 r = v.fixed_res ? fixed_r[b] : 8'($urandom);
          res_q.push_back(r); res_model.push_back(r);
        end
      end
    end

    @(negedge clk);
    num_shots = 16'(v.num_shots); start = 1'b1;
    @(negedge clk);
    while (!seen_done && cyc < 2000) begin
      if (v.restart && cyc == 3) begin start = 1'b1; num_shots = 16'd9; end
      else start = 1'b0;
      if (m_pend) begin meas_valid = 1'b0; m_pend = 0; end
      if (r_pend) begin res_valid = 1'b0; r_pend = 0; end
      case (v.mode)
        0:       dec_ready = 1'b1;
        1:       dec_ready = (cyc % 2 == 0);
        default: dec_ready = 1'($urandom_range(0, 1));
      endcase
      if (!meas_valid && src_q.size() > 0 && (!v.mgap || $urandom_range(0, 2) != 0)) begin
        meas_valid = 1'b1; meas_data = src_q[0];
      end
      if (!res_valid && res_q.size() > 0 && (!v.rgap || $urandom_range(0, 3) != 0)) begin
        res_valid = 1'b1; res_data = res_q[0];
      end
      #1;
      if (cyc == 0) chk("busy_after_start", busy, 1);
      if (wait_cycles >= 0) wait_cycles++;
      if (prev_stall) begin
        chk("dec_hold_valid", dec_valid, 1);
        chk("dec_hold_data", dec_data, prev_data);
      end
      prev_stall = dec_valid && !dec_ready;
      prev_data  = dec_data;
      if (exp_ctrl.size() == 0 || exp_ctrl[0]) chk("meas_ready_ctrl", meas_ready, 0);
      if (dec_valid && dec_ready) begin
        if (exp_dec.size() == 0) chk("dec_unexpected", dec_valid, 0);
        else begin
          chk("dec_byte", dec_data, exp_dec.pop_front());
          void'(exp_ctrl.pop_front());
        end
      end
      if (meas_valid && meas_ready) begin
        void'(src_q.pop_front()); m_pend = 1; meas_fired++;
        if (meas_fired % MEAS == 0) wait_cycles = 0;
      end
      if (res_valid && res_ready) begin
        void'(res_q.pop_front()); r_pend = 1; res_fired++;
        chk("res_after_meas", meas_fired, ((res_fired - 1) / RB + 1) * MEAS);
      end
      if (result_valid) begin
        if (res_count < res_model.size() / RB) begin
          chk("iterations", iterations, res_model[RB*res_count]);
          chk("cycles", cycles, int'(res_model[RB*res_count+1]) * 256 + int'(res_model[RB*res_count+2]));
        end else chk("result_extra", result_valid, 0);
        chk("shot_index", shot_index, res_count + 1);
        res_count++;
        last_rv = cyc;
      end
      if (session_done) begin
        seen_done = 1;
        if (!expect_timeout) chk("done_lag", cyc - last_rv, 1);
      end
`ifdef DECODE_TIMEOUT_EN
      if (expect_timeout && wait_cycles == 16) chk("timeout_early", timeout, 0);
      if (expect_timeout && wait_cycles == 17) chk("timeout_set", timeout, 1);
`endif
      cyc++;
      @(negedge clk);
    end
    chk("session_done_seen", seen_done, 1);
    chk("result_count", res_count, expect_timeout ? 0 : v.exp_shots);
    chk("final_shot_index", shot_index, expect_timeout ? 0 : v.exp_shots);
    chk("dec_remaining", exp_dec.size(), 0);
`ifdef DECODE_TIMEOUT_EN
    chk("timeout_flag", timeout, expect_timeout);
`endif
    start = 1'b0; meas_valid = 1'b0; res_valid = 1'b0; dec_ready = 1'b0;
    #1;
    chk("done_one_cycle", session_done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic reset_mid();
    int fires = 0, n = 0;
    @(negedge clk);
    num_shots = 16'd2; start = 1'b1; dec_ready = 1'b1; meas_valid = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (fires < 2 && n < 20) begin
      #1;
      if (dec_valid && dec_ready) fires++;
      n++;
      @(negedge clk);
    end
    chk("mid_hdr_sent", fires, 2);
    dec_ready = 1'b0; meas_valid = 1'b1; meas_data = 8'hA5;
    #1;
    chk("mid_passthru_valid", dec_valid, 1);
    chk("mid_passthru_data", dec_data, 8'hA5);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dec_valid", dec_valid, 0);
    meas_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t tv;
    vecs[0] = '{1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2, 2, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4, 4, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{5, 5, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) run_session(vecs[i], 1'b0);
    reset_mid();
    run_session(vecs[0], 1'b0);
`ifdef DECODE_TIMEOUT_EN
    tv = '{2, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_session(tv, 1'b1);
    run_session(vecs[1], 1'b0);
`else
    tv = vecs[3];
    run_session(tv, 1'b0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
